// File: rtl/result_serializer.sv
// result_serializer: snapshots a flat multi-element result on load and streams it byte by byte to a UART transmitter.
// Latency: busy rises 1 cycle after load; first tx_start follows 1 cycle after the transmitter is seen idle.
// Backpressure: waits in SEND while i_tx_busy is high; each byte waits for a busy rise then fall before advancing.
//
// Ports:
//   i_clk       system clock (same domain as the transmitter)
//   i_rst       asynchronous active-high reset
//   i_load      one-cycle request to capture i_result and start a frame (ignored while a frame is in progress)
//   i_result    flat product, element k at [k*ELEM_W +: ELEM_W]
//   i_tx_busy   transmitter busy flag
//   o_tx_data   byte presented to the transmitter, stable from tx_start until that byte completes
//   o_tx_start  one-cycle transmit request
//   o_busy      frame in progress
//   o_done      one-cycle pulse after the last byte completes
module result_serializer #(
    parameter int         NUM_ELEMS = 9,
    parameter int         ELEM_W    = 16,
    parameter bit         HDR_EN    = 1'b1,
    parameter logic [7:0] HDR_BYTE  = 8'hA5
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_load,
    input  logic [NUM_ELEMS*ELEM_W-1:0] i_result,
    input  logic                        i_tx_busy,
    output logic [7:0]                  o_tx_data,
    output logic                        o_tx_start,
    output logic                        o_busy,
    output logic                        o_done
);

    localparam int PAY_BYTES = NUM_ELEMS * ELEM_W / 8;
    localparam int HDR_N     = HDR_EN ? 1 : 0;
    localparam int FRAME_N   = PAY_BYTES + HDR_N;
    localparam int IDX_W     = (FRAME_N > 1) ? $clog2(FRAME_N) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_N - 1);
    localparam logic [IDX_W-1:0] HDR_OFS  = IDX_W'(HDR_N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_ACK,
        S_WAIT_IDLE,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_shadow [PAY_BYTES];
    logic [7:0]       r_tx_data;
    logic             r_tx_start;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [IDX_W-1:0] w_pay_idx;
    logic             w_capture;
    logic [7:0]       w_cur_byte;
    logic [7:0]       w_tx_data_nxt;
    logic             w_tx_start_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    // Byte index 0 is the header when enabled; payload bytes follow in shadow order.
    always_comb begin
        w_pay_idx  = (r_idx >= HDR_OFS) ? (r_idx - HDR_OFS) : '0;
        w_cur_byte = r_shadow[w_pay_idx];
        if (HDR_EN && (r_idx == '0)) begin
            w_cur_byte = HDR_BYTE;
        end
    end

    // Next-state and next-output logic. Outputs are derived from the next
    // state so that the registered values line up with the state they describe.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_capture      = 1'b0;
        w_tx_data_nxt  = r_tx_data;
        w_tx_start_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_load) begin
                    w_capture   = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (!i_tx_busy) begin
                    w_tx_data_nxt  = w_cur_byte;
                    w_tx_start_nxt = 1'b1;
                    w_state_nxt    = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (i_tx_busy) begin
                    w_state_nxt = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (!i_tx_busy) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt   = r_idx + 1'b1;
                        w_state_nxt = S_SEND;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == S_SEND) || (w_state_nxt == S_WAIT_ACK) ||
                     (w_state_nxt == S_WAIT_IDLE);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            for (int b = 0; b < PAY_BYTES; b++) begin
                r_shadow[b] <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            if (w_capture) begin
                for (int b = 0; b < PAY_BYTES; b++) begin
                    r_shadow[b] <= i_result[b*8 +: 8];
                end
            end
        end
    end

    assign o_tx_data  = r_tx_data;
    assign o_tx_start = r_tx_start;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: tb/tb_result_serializer.sv
// tb_result_serializer: drives result_serializer (with and without header) through directed and random frames.
// A transmitter model answers tx_start with a configurable ack delay and busy width.
// A protocol-level model (expected byte queue plus handshake progress) is checked against the DUT every cycle.
module tb_result_serializer;

    localparam int NE = 9;
    localparam int EW = 16;
    localparam int RW = NE * EW;
    localparam int NB = RW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [RW-1:0] result;
    logic          tx_busy;
    logic [7:0]    tx_data,  tx_data0;
    logic          tx_start, tx_start0;
    logic          busy,     busy0;
    logic          done,     done0;

    result_serializer #(.NUM_ELEMS(NE), .ELEM_W(EW), .HDR_EN(1'b1), .HDR_BYTE(8'hA5)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_load(load), .i_result(result), .i_tx_busy(tx_busy),
        .o_tx_data(tx_data), .o_tx_start(tx_start), .o_busy(busy), .o_done(done)
    );

    result_serializer #(.NUM_ELEMS(NE), .ELEM_W(EW), .HDR_EN(1'b0), .HDR_BYTE(8'hA5)) u_dut_nohdr (
        .i_clk(clk), .i_rst(rst), .i_load(load), .i_result(result), .i_tx_busy(tx_busy),
        .o_tx_data(tx_data0), .o_tx_start(tx_start0), .o_busy(busy0), .o_done(done0)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- transmitter model ----------------
    int ack_lat  = 1;
    int hold_len = 10;
    int pre_cnt  = 0;
    bit rnd_tx   = 1'b0;
    int lat_cnt  = 0;
    int hold_cnt = 0;

    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                lat_cnt  = 0;
                hold_cnt = 0;
                pre_cnt  = 0;
                tx_busy  = 1'b0;
            end else begin
                if (tx_start) begin
                    lat_cnt = rnd_tx ? int'($urandom_range(1, 4)) : ack_lat;
                end else if (lat_cnt > 0) begin
                    lat_cnt--;
                    if (lat_cnt == 0) hold_cnt = rnd_tx ? int'($urandom_range(1, 12)) : hold_len;
                end
                if (hold_cnt > 0) begin
                    tx_busy = 1'b1;
                    hold_cnt--;
                end else if (pre_cnt > 0) begin
                    tx_busy = 1'b1;
                    pre_cnt--;
                end else begin
                    tx_busy = 1'b0;
                end
            end
        end
    end

    // ---------------- reference model + compare ----------------
    // m_phase: 0 idle, 1 byte waiting for an idle transmitter, 2 byte in flight, 3 done cycle
    int            m_phase = 0;
    bit            m_busy  = 1'b0;
    bit            m_seen  = 1'b0;
    logic [7:0]    m_cur   = '0;
    logic [7:0]    m_q [$];
    logic          prev_load = 1'b0;
    logic          prev_txb  = 1'b0;
    logic [RW-1:0] prev_result = '0;

    logic [7:0]    log1 [$];
    logic [7:0]    log0 [$];
    int            done1_cnt = 0;
    int            done0_cnt = 0;

    initial begin
        bit exp_start;
        bit exp_done;
        forever begin
            @(negedge clk);
            if (tx_start)  log1.push_back(tx_data);
            if (tx_start0) log0.push_back(tx_data0);
            if (done)      done1_cnt++;
            if (done0)     done0_cnt++;
            if (rst) begin
                m_phase = 0;
                m_busy  = 1'b0;
                m_q.delete();
                chk("rst_outputs", {21'd0, tx_data, tx_start, busy, done}, 32'd0);
            end else begin
                exp_start = 1'b0;
                exp_done  = 1'b0;
                case (m_phase)
                    0: if (prev_load) begin
                        m_q.delete();
                        m_q.push_back(8'hA5);
                        for (int j = 0; j < NB; j++) m_q.push_back(prev_result[j*8 +: 8]);
                        m_busy  = 1'b1;
                        m_phase = 1;
                    end
                    1: if (!prev_txb) begin
                        exp_start = 1'b1;
                        m_cur     = m_q.pop_front();
                        m_seen    = 1'b0;
                        m_phase   = 2;
                    end
                    2: begin
                        if (prev_txb) begin
                            m_seen = 1'b1;
                        end else if (m_seen) begin
                            if (m_q.size() == 0) begin
                                exp_done = 1'b1;
                                m_busy   = 1'b0;
                                m_phase  = 3;
                            end else begin
                                m_phase = 1;
                            end
                        end
                    end
                    default: m_phase = 0;
                endcase
                chk("tx_start", 32'(tx_start), 32'(exp_start));
                chk("done",     32'(done),     32'(exp_done));
                chk("busy",     32'(busy),     32'(m_busy));
                if (m_phase == 2) chk("tx_data", 32'(tx_data), 32'(m_cur));
            end
            prev_load   = load;
            prev_txb    = tx_busy;
            prev_result = result;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int cyc;
        cyc = 0;
        while (!done && cyc < budget) begin
            tick();
            cyc++;
        end
        if (!done) chk({"timeout_", nm}, 32'd0, 32'd1);
    endtask

    task automatic wait_log(input string nm, input int n, input int budget);
        int cyc;
        cyc = 0;
        while (log1.size() < n && cyc < budget) begin
            tick();
            cyc++;
        end
        if (log1.size() < n) chk({"timeout_", nm}, 32'(log1.size()), 32'(n));
    endtask

    task automatic pulse_load();
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    function automatic logic [RW-1:0] s1_res();
        logic [RW-1:0] r;
        r = '0;
        for (int k = 0; k < NE; k++) r[k*EW +: EW] = 16'h1000 + 16'(k) * 16'h0101;
        return r;
    endfunction

    function automatic logic [RW-1:0] rand_res();
        logic [159:0] t;
        for (int i = 0; i < 5; i++) t[i*32 +: 32] = $urandom;
        return t[RW-1:0];
    endfunction

    // Frame j of the first test pattern: A5, then element k low byte k, high byte 0x10+k.
    function automatic logic [7:0] s1_byte(input int j);
        int p;
        if (j == 0) return 8'hA5;
        p = j - 1;
        return (p % 2 == 0) ? 8'(p / 2) : 8'(16 + p / 2);
    endfunction

    task automatic check_frame(input string nm, input int off);
        for (int j = 0; j < 19; j++) begin
            chk({nm, "_byte"}, 32'(log1[off + j]), 32'(s1_byte(j)));
        end
    endtask

    task automatic clear_logs();
        log1.delete();
        log0.delete();
        done1_cnt = 0;
        done0_cnt = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit saw_a5;
        rst    = 1'b1;
        load   = 1'b0;
        result = '0;
        repeat (3) tick();
        chk("reset_tx_data",  32'(tx_data),  32'd0);
        chk("reset_tx_start", 32'(tx_start), 32'd0);
        chk("reset_busy",     32'(busy),     32'd0);
        chk("reset_done",     32'(done),     32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Scenario 1: default frame, plus the header-less instance on the same handshake.
        clear_logs();
        result = s1_res();
        pulse_load();
        wait_done("s1", 2000);
        repeat (15) tick();
        chk("s1_count",  32'(log1.size()), 32'd19);
        chk("s1_b0",     32'(log1[0]),  32'h0A5);
        chk("s1_b1",     32'(log1[1]),  32'h000);
        chk("s1_b2",     32'(log1[2]),  32'h010);
        chk("s1_b3",     32'(log1[3]),  32'h001);
        chk("s1_b4",     32'(log1[4]),  32'h011);
        chk("s1_b18",    32'(log1[18]), 32'h018);
        check_frame("s1", 0);
        chk("s1_dones",  32'(done1_cnt), 32'd1);
        chk("nohdr_count", 32'(log0.size()), 32'd18);
        chk("nohdr_b0",    32'(log0[0]), 32'h000);
        chk("nohdr_b1",    32'(log0[1]), 32'h010);
        chk("nohdr_b17",   32'(log0[17]), 32'h018);
        saw_a5 = 1'b0;
        foreach (log0[i]) if (log0[i] == 8'hA5) saw_a5 = 1'b1;
        chk("nohdr_no_a5", 32'(saw_a5), 32'd0);
        chk("nohdr_dones", 32'(done0_cnt), 32'd1);

        // Scenario 2: transmitter busy at load, slow ack.
        clear_logs();
        ack_lat  = 4;
        hold_len = 3;
        pre_cnt  = 7;
        tick();
        chk("s2_busy_at_load", 32'(tx_busy), 32'd1);
        pulse_load();
        wait_done("s2", 2000);
        tick();
        chk("s2_count", 32'(log1.size()), 32'd19);
        check_frame("s2", 0);

        // Scenario 3: load re-pulsed mid-frame and in the done cycle.
        clear_logs();
        ack_lat  = 1;
        hold_len = 10;
        pulse_load();
        wait_log("s3_byte5", 5, 1000);
        result = ~s1_res();
        pulse_load();
        wait_done("s3", 2000);
        load = 1'b1;
        tick();
        load = 1'b0;
        result = s1_res();
        repeat (40) tick();
        chk("s3_count", 32'(log1.size()), 32'd19);
        check_frame("s3", 0);
        chk("s3_dones", 32'(done1_cnt), 32'd1);
        chk("s3_idle",  32'(busy), 32'd0);

        // Scenario 4: asynchronous reset while byte 7 is in flight.
        clear_logs();
        pulse_load();
        wait_log("s4_byte7", 8, 1000);
        begin
            int cyc;
            cyc = 0;
            while (!tx_busy && cyc < 50) begin
                tick();
                cyc++;
            end
        end
        repeat (2) tick();
        chk("s4_busy_before_rst", 32'(busy), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_tx_data", 32'(tx_data), 32'd0);
        chk("arst_busy",    32'(busy),    32'd0);
        chk("arst_start",   32'(tx_start), 32'd0);
        chk("arst_done",    32'(done),    32'd0);
        tick();
        tick();
        rst = 1'b0;
        clear_logs();
        repeat (20) tick();
        chk("s4_no_start_after_rst", 32'(log1.size()), 32'd0);
        pulse_load();
        wait_done("s4", 2000);
        tick();
        chk("s4_count", 32'(log1.size()), 32'd19);
        check_frame("s4", 0);

        // Scenario 5: back-to-back frames, load in the cycle after done.
        clear_logs();
        pulse_load();
        wait_done("s5a", 2000);
        tick();
        pulse_load();
        wait_done("s5b", 2000);
        tick();
        chk("s5_count", 32'(log1.size()), 32'd38);
        check_frame("s5a", 0);
        check_frame("s5b", 19);
        chk("s5_dones", 32'(done1_cnt), 32'd2);

        // Scenario 6: random data, random transmitter timing, load spam and result churn.
        rnd_tx = 1'b1;
        for (int f = 0; f < 6; f++) begin
            int cyc;
            result = rand_res();
            pulse_load();
            cyc = 0;
            while (!done && cyc < 3000) begin
                result = rand_res();
                load   = ($urandom_range(0, 7) == 0);
                tick();
                cyc++;
            end
            if (!done) chk("timeout_rand", 32'd0, 32'd1);
            load = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete (compared %0d, mismatched %0d)", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/result_serializer.md
Name: result_serializer

Overview:
- Downstream stage of the matrix multiplier; consumes the flat 144-bit product (9 elements x 16 bits) and drives the UART transmitter one byte at a time.
- Snapshots the result on a load pulse, optionally prefixes a sync header byte, then streams the payload in a fixed byte order with a start/busy handshake against the transmitter.
- Signals completion to the control unit so it can return to IDLE.

Parameters:
- NUM_ELEMS, 9, number of result elements.
- ELEM_W, 16, bits per element; must be a multiple of 8.
- HDR_EN, 1, 1 = send HDR_BYTE before the payload; 0 = payload only.
- HDR_BYTE, 8'hA5, sync header value.

Ports:
- clk  input  1  system clock (same domain as uart_tx).
- rst  input  1  asynchronous, active-high reset.
- load  input  1  one-cycle request to capture result and start a frame.
- result  input  NUM_ELEMS*ELEM_W  flat product; element k at bits [k*ELEM_W +: ELEM_W].
- tx_busy  input  1  transmitter busy flag.
- tx_data  output  8  byte presented to the transmitter.
- tx_start  output  1  one-cycle transmit request.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse after the last byte completes.

Behaviour:
- Reset (async, any state): state=IDLE; tx_data=0, tx_start=0, busy=0, done=0; shadow register and byte index cleared. Any frame in flight is abandoned, and no further tx_start is issued until the next load.
- Frame length: N = NUM_ELEMS*ELEM_W/8 + HDR_EN, which is 19 with the defaults.
- Byte order:
  - Header first (if HDR_EN=1).
  - Then element 0..NUM_ELEMS-1, each little-endian (low byte first).
  - Payload byte j = shadow[j*8 +: 8].
- All outputs are registered.
- States:
  - IDLE: busy=0. When load=1, capture result into the shadow register, clear the byte index, and go to SEND; busy=1 from the next cycle.
  - SEND: while tx_busy=1, wait. When tx_busy=0, drive tx_data=current byte, pulse tx_start=1 for exactly one cycle, and go to WAIT_ACK.
  - WAIT_ACK: hold tx_data. When tx_busy=1, go to WAIT_IDLE.
  - WAIT_IDLE: hold tx_data. When tx_busy=0: if this was the last byte, go to DONE; otherwise increment the index and go to SEND.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
- tx_data remains stable from the tx_start cycle until the byte completes (WAIT_IDLE exit).
- load while busy=1 (including the DONE cycle) is ignored; the shadow register is not overwritten. The result input may change freely after the load cycle.
- load held high for several cycles in IDLE starts exactly one frame. A new frame needs load to be re-asserted after DONE.
- Minimum spacing between successive tx_start pulses is 3 cycles: SEND, WAIT_ACK, then WAIT_IDLE with at least one cycle of tx_busy.
- The byte index width is clog2(N). The index never wraps within a frame; it is reset at load.

Test Plan:
- Defaults. result element k = 16'h1000 + k*16'h0101. Pulse load; the transmitter model raises tx_busy 1 cycle after tx_start and holds it 10 cycles. Required: 19 tx_start pulses with bytes A5,00,10,01,11,02,12,...,08,18. After the last busy falls, exactly one done pulse; busy high from the cycle after load through the last WAIT_IDLE.
- HDR_EN=0, same stimulus. Required: 18 bytes starting 00,10; no A5 sent.
- Stretched handshake. tx_busy is already high at load and stays high 5 more cycles; later ack latency is 4 cycles. Required: no tx_start while tx_busy=1; each tx_start is exactly 1 cycle wide; tx_data is constant across each byte.
- Load while busy. Re-pulse load with a different result at byte 5 and again in the DONE cycle. Required: frame content unchanged, total 19 bytes, a single done pulse, no second frame.
- Reset mid-frame. Assert rst during byte 7's WAIT_IDLE. Required: all outputs 0 immediately (async). After release, no tx_start without load; a new load sends a full 19-byte frame starting with A5.
- Back-to-back frames. Issue load in the cycle after done. Required: the second frame starts; the sequence is identical to scenario 1 when the same result is applied.
